// File: rtl/du_transmit.sv
// Debug-unit dump serializer: streams PC, cycle count, register file and data memory as bytes to a UART.
// Optional macro DU_TX_MEM_DIRTY_FILTER_EN: only memory words with their dirty bit set are sent.
module du_transmit #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_REG  = 5,
  parameter int unsigned N_REGS  = 32,
  parameter int unsigned NB_ADDR = 7,
  parameter int unsigned N_MEM   = 128
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_pc,
  input  logic [NB_DATA-1:0] i_cant_cycles,
  output logic [NB_REG-1:0]  o_addr_reg,
  input  logic [NB_DATA-1:0] i_reg_data,
  output logic [NB_ADDR-1:0] o_addr_mem,
  input  logic [NB_DATA-1:0] i_mem_data,
  input  logic               i_mem_dirty,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done
);
  localparam int unsigned NB_BYTES = NB_DATA / 8;
  localparam int unsigned NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
`ifdef DU_TX_MEM_DIRTY_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, SEND_PC, SEND_CYC, REG_RD, REG_TX, MEM_RD, MEM_CHK,
    MEM_ADDR_TX, MEM_DATA_TX, SEND_EOF, DONE
  } state_t;

  state_t               r_state, w_state;
  logic [NB_DATA-1:0]   r_shift, w_shift;
  logic [NB_DATA-1:0]   r_cyc, w_cyc;
  logic [NB_BCNT-1:0]   r_bcnt, w_bcnt;
  logic                 r_wait, w_wait;
  logic [NB_REG-1:0]    r_addr_reg, w_addr_reg;
  logic [NB_ADDR-1:0]   r_addr_mem, w_addr_mem;
  logic [7:0]           r_tx_data, w_tx_data;
  logic                 r_tx_start, w_tx_start;
  logic                 r_busy, r_done;
  logic                 w_byte_done, w_mem_next;
  logic                 w_tx_state, w_last_byte;
  logic [7:0]           w_cur_byte;

  assign w_tx_state  = (r_state == SEND_PC) || (r_state == SEND_CYC) || (r_state == REG_TX) ||
                       (r_state == MEM_ADDR_TX) || (r_state == MEM_DATA_TX) || (r_state == SEND_EOF);
  assign w_last_byte = (r_bcnt == NB_BCNT'(NB_BYTES - 1));
  assign w_cur_byte  = (r_state == MEM_ADDR_TX) ? 8'(r_addr_mem) :
                       (r_state == SEND_EOF)    ? 8'hFF : r_shift[7:0];

  // Next-state, datapath and handshake logic
  always_comb begin
    w_state     = r_state;
    w_shift     = r_shift;
    w_cyc       = r_cyc;
    w_bcnt      = r_bcnt;
    w_wait      = r_wait;
    w_addr_reg  = r_addr_reg;
    w_addr_mem  = r_addr_mem;
    w_tx_data   = r_tx_data;
    w_tx_start  = r_tx_start;
    w_byte_done = 1'b0;
    w_mem_next  = 1'b0;

    // Raise a request when idle on the line; data only changes while the request is low
    if (w_tx_state) begin
      if (!r_tx_start) begin
        w_tx_start = 1'b1;
        w_tx_data  = w_cur_byte;
      end else if (i_tx_done) begin
        w_tx_start  = 1'b0;
        w_byte_done = 1'b1;
      end
    end

    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state = SEND_PC;
          w_shift = i_pc;
          w_cyc   = i_cant_cycles;
          w_bcnt  = '0;
        end
      end
      SEND_PC, SEND_CYC, REG_TX, MEM_DATA_TX: begin
        if (w_byte_done) begin
          w_shift = r_shift >> 8;
          w_bcnt  = w_last_byte ? '0 : r_bcnt + NB_BCNT'(1);
          if (w_last_byte) begin
            if (r_state == SEND_PC) begin
              w_shift = r_cyc;
              w_state = SEND_CYC;
            end else if (r_state == SEND_CYC) begin
              w_wait  = 1'b0;
              w_state = REG_RD;
            end else if (r_state == REG_TX) begin
              if (r_addr_reg == NB_REG'(N_REGS - 1)) begin
                w_addr_mem = '0;
                w_state    = MEM_RD;
              end else begin
                w_addr_reg = r_addr_reg + NB_REG'(1);
                w_state    = REG_RD;
              end
            end else begin
              w_mem_next = 1'b1;
            end
          end
        end
      end
      REG_RD: begin
        if (!r_wait) begin
          w_wait = 1'b1;
        end else begin
          w_wait  = 1'b0;
          w_shift = i_reg_data;
          w_bcnt  = '0;
          w_state = REG_TX;
        end
      end
      MEM_RD: w_state = MEM_CHK;
      MEM_CHK: begin
        w_shift = i_mem_data;
        w_bcnt  = '0;
        if (!FILTER_EN || i_mem_dirty) begin
          w_state = MEM_ADDR_TX;
        end else begin
          w_mem_next = 1'b1;
        end
      end
      MEM_ADDR_TX: if (w_byte_done) w_state = MEM_DATA_TX;
      SEND_EOF:    if (w_byte_done) w_state = DONE;
      DONE: begin
        w_addr_reg = '0;
        w_addr_mem = '0;
        w_state    = IDLE;
      end
      default: w_state = IDLE;
    endcase

    // Advance the memory scan without wrapping past the last word
    if (w_mem_next) begin
      if (r_addr_mem == NB_ADDR'(N_MEM - 1)) begin
        w_state = SEND_EOF;
      end else begin
        w_addr_mem = r_addr_mem + NB_ADDR'(1);
        w_state    = MEM_RD;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_cyc      <= '0;
      r_bcnt     <= '0;
      r_wait     <= 1'b0;
      r_addr_reg <= '0;
      r_addr_mem <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_shift    <= w_shift;
      r_cyc      <= w_cyc;
      r_bcnt     <= w_bcnt;
      r_wait     <= w_wait;
      r_addr_reg <= w_addr_reg;
      r_addr_mem <= w_addr_mem;
      r_tx_data  <= w_tx_data;
      r_tx_start <= w_tx_start;
      r_busy     <= (w_state != IDLE);
      r_done     <= (w_state == DONE);
    end
  end

  assign o_addr_reg = r_addr_reg;
  assign o_addr_mem = r_addr_mem;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
endmodule

// File: tb/tb_du_transmit.sv
// Bench for du_transmit: UART/regfile/memory models, a frame model built from plain arrays, and pinned literal bytes.
module tb_du_transmit;
  localparam int unsigned NB_DATA = 32;
  localparam int unsigned NB_REG  = 5;
  localparam int unsigned N_REGS  = 32;
  localparam int unsigned NB_ADDR = 7;
  localparam int unsigned N_MEM   = 128;
`ifdef DU_TX_MEM_DIRTY_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic               i_clock = 1'b0;
  logic               i_reset = 1'b0;
  logic               i_start = 1'b0;
  logic [NB_DATA-1:0] i_pc = '0;
  logic [NB_DATA-1:0] i_cant_cycles = '0;
  logic [NB_REG-1:0]  o_addr_reg;
  logic [NB_DATA-1:0] i_reg_data = '0;
  logic [NB_ADDR-1:0] o_addr_mem;
  logic [NB_DATA-1:0] i_mem_data = '0;
  logic               i_mem_dirty = 1'b0;
  logic [7:0]         o_tx_data;
  logic               o_tx_start;
  logic               i_tx_done;
  logic               o_busy;
  logic               o_done;

  logic uart_done = 1'b0;
  logic spur_done = 1'b0;
  assign i_tx_done = uart_done | spur_done;

  du_transmit #(
    .NB_DATA(NB_DATA), .NB_REG(NB_REG), .N_REGS(N_REGS), .NB_ADDR(NB_ADDR), .N_MEM(N_MEM)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_pc(i_pc),
    .i_cant_cycles(i_cant_cycles), .o_addr_reg(o_addr_reg), .i_reg_data(i_reg_data),
    .o_addr_mem(o_addr_mem), .i_mem_data(i_mem_data), .i_mem_dirty(i_mem_dirty),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clock = ~i_clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file and data memory with one-cycle read latency
  logic [31:0] regs     [N_REGS];
  logic [31:0] mem_data [N_MEM];
  logic        mem_dirty[N_MEM];
  always @(posedge i_clock) begin
    i_reg_data  <= regs[o_addr_reg];
    i_mem_data  <= mem_data[o_addr_mem];
    i_mem_dirty <= mem_dirty[o_addr_mem];
  end

  // Frame model: what the byte stream must be for given snapshots and memory contents
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic build_frame(input logic [31:0] pc, input logic [31:0] cyc);
    exp_q.delete();
    push_word(pc);
    push_word(cyc);
    for (int k = 0; k < N_REGS; k++) push_word(regs[k]);
    for (int a = 0; a < N_MEM; a++) begin
      if (!FILTER || mem_dirty[a]) begin
        exp_q.push_back(8'(a));
        push_word(mem_data[a]);
      end
    end
    exp_q.push_back(8'hFF);
  endtask

  // UART responder: acknowledges each request after 1..dly_max cycles
  int unsigned dly_max = 1;
  int unsigned dly;
  always begin
    @(negedge i_clock);
    if (o_tx_start) begin
      dly = $urandom_range(1, dly_max);
      repeat (dly - 1) @(negedge i_clock);
      @(posedge i_clock);
      #1;
      if (o_tx_start) uart_done = 1'b1;
      @(posedge i_clock);
      #1;
      uart_done = 1'b0;
    end
  end

  // Per-cycle monitor: byte content, data stability, request drop, frame length at o_done
  logic       mon_en = 1'b0;
  logic       prev_start = 1'b0;
  logic       prev_ack = 1'b0;
  logic [7:0] held = '0;
  int         done_cnt = 0;
  always @(negedge i_clock) begin
    if (mon_en) begin
      if (o_tx_start && !prev_start) begin
        if (rx_q.size() < exp_q.size()) chk("tx_byte", 32'(o_tx_data), 32'(exp_q[rx_q.size()]));
        else chk("extra_byte", 32'(rx_q.size()), 32'(exp_q.size()));
        rx_q.push_back(o_tx_data);
        held = o_tx_data;
        chk("busy_while_tx", 32'(o_busy), 32'd1);
      end else if (o_tx_start) begin
        chk("tx_data_stable", 32'(o_tx_data), 32'(held));
      end
      if (prev_ack) chk("tx_start_drop", 32'(o_tx_start), 32'd0);
      if (o_done) begin
        done_cnt++;
        chk("len_at_done", 32'(rx_q.size()), 32'(exp_q.size()));
      end
      prev_ack   = o_tx_start && i_tx_done;
      prev_start = o_tx_start;
    end else begin
      prev_ack   = 1'b0;
      prev_start = 1'b0;
    end
  end

  task automatic run_frame(input logic [31:0] pc, input logic [31:0] cyc,
                           input int unsigned dmax, input bit disturb);
    bit seen;
    bit pulsed;
    seen   = 1'b0;
    pulsed = 1'b0;
    build_frame(pc, cyc);
    rx_q.delete();
    done_cnt = 0;
    dly_max  = dmax;
    @(negedge i_clock);
    i_pc = pc;
    i_cant_cycles = cyc;
    i_start = 1'b1;
    @(negedge i_clock);
    i_start = 1'b0;
    if (disturb) begin
      i_pc = ~pc;
      i_cant_cycles = ~cyc;
    end
    for (int c = 0; c < 60000 && !seen; c++) begin
      @(negedge i_clock);
      i_start = 1'b0;
      if (disturb && !pulsed && rx_q.size() == 20) begin
        i_start = 1'b1;
        pulsed  = 1'b1;
      end
      if (o_done) begin
        seen = 1'b1;
        if (disturb) i_start = 1'b1;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    @(negedge i_clock);
    i_start = 1'b0;
    repeat (20) @(negedge i_clock);
    chk("frame_len", 32'(rx_q.size()), 32'(exp_q.size()));
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_tx_start", 32'(o_tx_start), 32'd0);
    chk("addr_reg_zero", 32'(o_addr_reg), 32'd0);
    chk("addr_mem_zero", 32'(o_addr_mem), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < N_REGS; k++) regs[k] = 32'h1111_0000 + 32'(k);
    for (int a = 0; a < N_MEM; a++) begin
      mem_data[a]  = {8'hA5, 8'(a), 8'(~a), 8'(a * 3)};
      mem_dirty[a] = 1'b0;
    end
    mem_data[5]    = 32'hDEAD_BEEF;
    mem_data[127]  = 32'h0000_0001;
    mem_dirty[5]   = 1'b1;
    mem_dirty[127] = 1'b1;

    repeat (3) @(negedge i_clock);
    chk("rst_tx_start", 32'(o_tx_start), 32'd0);
    chk("rst_tx_data", 32'(o_tx_data), 32'd0);
    chk("rst_addr_reg", 32'(o_addr_reg), 32'd0);
    chk("rst_addr_mem", 32'(o_addr_mem), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    i_reset = 1'b1;
    mon_en  = 1'b1;

    // Frame 1: fast UART, words 5 and 127 dirty
    run_frame(32'h0000_0012, 32'h0000_0034, 1, 1'b0);
    chk("f1_pc_b0", 32'(rx_q[0]), 32'h12);
    chk("f1_pc_b1", 32'(rx_q[1]), 32'h00);
    chk("f1_cyc_b0", 32'(rx_q[4]), 32'h34);
    chk("f1_reg0_b0", 32'(rx_q[8]), 32'h00);
    chk("f1_reg0_b2", 32'(rx_q[10]), 32'h11);
    chk("f1_reg31_b0", 32'(rx_q[132]), 32'h1F);
    chk("f1_reg31_b3", 32'(rx_q[135]), 32'h11);
`ifdef DU_TX_MEM_DIRTY_FILTER_EN
    chk("f1_len_lit", 32'(rx_q.size()), 32'd147);
    chk("f1_m0", 32'(rx_q[136]), 32'h05);
    chk("f1_m1", 32'(rx_q[137]), 32'hEF);
    chk("f1_m2", 32'(rx_q[138]), 32'hBE);
    chk("f1_m3", 32'(rx_q[139]), 32'hAD);
    chk("f1_m4", 32'(rx_q[140]), 32'hDE);
    chk("f1_m5", 32'(rx_q[141]), 32'h7F);
    chk("f1_m6", 32'(rx_q[142]), 32'h01);
    chk("f1_m9", 32'(rx_q[145]), 32'h00);
    chk("f1_eof", 32'(rx_q[146]), 32'hFF);
`else
    chk("f1_len_lit", 32'(rx_q.size()), 32'd777);
    chk("f1_addr0", 32'(rx_q[136]), 32'h00);
    chk("f1_addr1", 32'(rx_q[141]), 32'h01);
    chk("f1_addr5", 32'(rx_q[161]), 32'h05);
    chk("f1_w5_b0", 32'(rx_q[162]), 32'hEF);
    chk("f1_w5_b3", 32'(rx_q[165]), 32'hDE);
    chk("f1_addr127", 32'(rx_q[771]), 32'h7F);
    chk("f1_w127_b0", 32'(rx_q[772]), 32'h01);
    chk("f1_eof", 32'(rx_q[776]), 32'hFF);
`endif

    // Frame 2: no dirty words, slow random UART, inputs changed and starts ignored while busy
    for (int a = 0; a < N_MEM; a++) mem_dirty[a] = 1'b0;
    run_frame(32'hCAFE_0001, 32'h0000_BEEF, 20, 1'b1);
    chk("f2_len_lit", 32'(rx_q.size()), FILTER ? 32'd137 : 32'd777);
    chk("f2_pc_b0", 32'(rx_q[0]), 32'h01);
    chk("f2_pc_b3", 32'(rx_q[3]), 32'hCA);
    chk("f2_cyc_b1", 32'(rx_q[5]), 32'hBE);

    // Frame 3: reset mid-frame, then a spurious ack while idle, then a clean restart
    build_frame(32'h5555_5555, 32'h6666_6666);
    rx_q.delete();
    dly_max = 1;
    @(negedge i_clock);
    i_pc = 32'h5555_5555;
    i_cant_cycles = 32'h6666_6666;
    i_start = 1'b1;
    @(negedge i_clock);
    i_start = 1'b0;
    for (int c = 0; c < 20000 && rx_q.size() < 60; c++) @(negedge i_clock);
    chk("reached_byte60", 32'(rx_q.size()), 32'd60);
    i_reset = 1'b0;
    mon_en  = 1'b0;
    @(negedge i_clock);
    chk("abort_tx_start", 32'(o_tx_start), 32'd0);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_tx_data", 32'(o_tx_data), 32'd0);
    chk("abort_addr_reg", 32'(o_addr_reg), 32'd0);
    @(negedge i_clock);
    i_reset = 1'b1;
    @(negedge i_clock);
    spur_done = 1'b1;
    @(negedge i_clock);
    spur_done = 1'b0;
    repeat (3) @(negedge i_clock);
    chk("spur_ack_tx_start", 32'(o_tx_start), 32'd0);
    chk("spur_ack_busy", 32'(o_busy), 32'd0);
    mon_en = 1'b1;
    run_frame(32'h0000_0077, 32'h0000_0099, 3, 1'b0);
    chk("restart_pc_b0", 32'(rx_q[0]), 32'h77);
    chk("restart_cyc_b0", 32'(rx_q[4]), 32'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
